// File: rtl/tlul_host_arbiter.sv
// N-host to 1-device TL-UL arbiter with source tagging and per-host outstanding limits.
// Define TLUL_ARB_DRSP_REG_EN to register the D channel through a 1-entry skid buffer.
package tlul_pkg;
    localparam int AIW = 8;

    typedef struct packed {
        logic           a_valid;
        logic [2:0]     a_opcode;
        logic [2:0]     a_size;
        logic [AIW-1:0] a_source;
        logic [31:0]    a_address;
        logic [3:0]     a_mask;
        logic [31:0]    a_data;
        logic           d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic           d_valid;
        logic [2:0]     d_opcode;
        logic [2:0]     d_size;
        logic [AIW-1:0] d_source;
        logic [31:0]    d_data;
        logic           d_error;
        logic           a_ready;
    } tl_d2h_t;
endpackage

module tlul_host_arbiter
    import tlul_pkg::*;
#(
    parameter int NumHosts       = 2,
    parameter int ArbMode        = 1,
    parameter int MaxOutstanding = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i [NumHosts],
    output tl_d2h_t tl_h_o [NumHosts],
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i,
    output logic    busy_o,
    output logic    err_o
);

    localparam int IdxW = (NumHosts > 2) ? $clog2(NumHosts) : 1;
    localparam logic [3:0] MaxCnt = 4'(MaxOutstanding);
    localparam logic [IdxW:0] NumIdx = (IdxW+1)'(NumHosts);

    logic [3:0]          cnt_q [NumHosts];
    logic [3:0]          cnt_d [NumHosts];
    logic                lock_q, lock_d;
    logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]     rr_q, rr_d;
    logic                err_q, err_d;

    logic [NumHosts-1:0] elig, inc, dec;
    logic                any_elig, win_valid, a_req, a_hs;
    logic [IdxW-1:0]     pick, win;
    tl_h2d_t             win_req;

    logic [IdxW-1:0]     dev_idx, rsp_idx;
    logic                dev_map, rsp_valid, host_rdy, dev_rdy, dev_hs, rsp_hs;
    tl_d2h_t             rsp;

`ifdef TLUL_ARB_DRSP_REG_EN
    tl_d2h_t             skid_q, skid_d;
    logic                skid_valid_q, skid_valid_d;
`endif

    always_comb begin
        int   c;
        logic found;
        c     = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NumHosts; i++) begin
            elig[i] = tl_h_i[i].a_valid && (cnt_q[i] < MaxCnt);
        end
        any_elig = |elig;
        if (ArbMode == 0) begin
            for (int i = NumHosts - 1; i >= 0; i--) begin
                if (elig[i]) pick = IdxW'(i);
            end
        end else begin
            // Scan starts just after the last granted host and wraps.
            for (int k = 1; k <= NumHosts; k++) begin
                c = (int'(rr_q) + k) % NumHosts;
                if (!found && elig[c]) begin
                    found = 1'b1;
                    pick  = IdxW'(c);
                end
            end
        end
        win       = lock_q ? lock_idx_q : pick;
        win_valid = lock_q | any_elig;
        win_req   = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (win == IdxW'(i)) win_req = tl_h_i[i];
        end
        a_req = !rst_i && win_valid;
        a_hs  = a_req && tl_d_i.a_ready;
    end

    always_comb begin
        dev_idx = tl_d_i.d_source[IdxW-1:0];
        dev_map = {1'b0, dev_idx} < NumIdx;
`ifdef TLUL_ARB_DRSP_REG_EN
        rsp       = skid_q;
        rsp_valid = skid_valid_q;
`else
        rsp       = tl_d_i;
        rsp_valid = tl_d_i.d_valid && dev_map;
`endif
        rsp_idx  = rsp.d_source[IdxW-1:0];
        host_rdy = 1'b0;
        for (int i = 0; i < NumHosts; i++) begin
            if (rsp_idx == IdxW'(i)) host_rdy = tl_h_i[i].d_ready;
        end
        rsp_hs = !rst_i && rsp_valid && host_rdy;
`ifdef TLUL_ARB_DRSP_REG_EN
        dev_rdy = !skid_valid_q || host_rdy;
`else
        // Unmapped responses are swallowed so the device never stalls on them.
        dev_rdy = !dev_map || host_rdy;
`endif
        dev_hs = !rst_i && tl_d_i.d_valid && dev_rdy;
        err_d  = dev_hs && !dev_map;
    end

    always_comb begin
        tl_d_o          = win_req;
        tl_d_o.a_valid  = a_req;
        tl_d_o.a_source = {win_req.a_source[AIW-1-IdxW:0], win};
        tl_d_o.d_ready  = !rst_i && dev_rdy;
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i]          = rsp;
            tl_h_o[i].d_source = rsp.d_source >> IdxW;
            tl_h_o[i].d_valid  = !rst_i && rsp_valid && (rsp_idx == IdxW'(i));
            tl_h_o[i].a_ready  = a_hs && (win == IdxW'(i));
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;
        if (a_hs) begin
            lock_d = 1'b0;
            rr_d   = win;
        end else if (a_req) begin
            lock_d     = 1'b1;
            lock_idx_d = win;
        end
        busy_o = 1'b0;
        for (int i = 0; i < NumHosts; i++) begin
            inc[i]   = a_hs && (win == IdxW'(i));
            dec[i]   = rsp_hs && (rsp_idx == IdxW'(i));
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !dec[i]) cnt_d[i] = cnt_q[i] + 4'd1;
            if (dec[i] && !inc[i]) cnt_d[i] = cnt_q[i] - 4'd1;
            if (cnt_q[i] != 4'd0) busy_o = 1'b1;
        end
        err_o = err_q;
`ifdef TLUL_ARB_DRSP_REG_EN
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (rsp_hs) skid_valid_d = 1'b0;
        if (dev_hs && dev_map) begin
            skid_valid_d = 1'b1;
            skid_d       = tl_d_i;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumHosts; i++) cnt_q[i] <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_q       <= IdxW'(NumHosts - 1);
            err_q      <= 1'b0;
`ifdef TLUL_ARB_DRSP_REG_EN
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_q       <= rr_d;
            err_q      <= err_d;
`ifdef TLUL_ARB_DRSP_REG_EN
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
`endif
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NumHosts; i++) begin
                assert (!(tl_h_i[i].a_valid && |tl_h_i[i].a_source[AIW-1 -: IdxW]));
                assert (!(dec[i] && !inc[i] && cnt_q[i] == 4'd0));
            end
        end
    end
`endif

endmodule
